track_recorder: RTL
===================

Name: track_recorder

Overview:
- Record path for the cellular RAM audio looper. Accepts 8-bit audio samples and writes them sequentially into one byte lane of the 16-bit memory: lower byte for track 0, upper byte for track 1.
- Drives the asynchronous write cycle that the playback controller never issues. It is the writer counterpart to the playback reader.
- A small FIFO absorbs sample bursts while a write cycle is in flight.

Parameters:
- FIFO_DEPTH, 4: sample buffer entries (power of two).
- WRITE_CYCLES, 7: cycles MemWR is held low (70 ns at 100 MHz).
- LAST_ADDR, 21'h1FFFFF: final word address of a recording. Must be greater than 0.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- record_en  input  1  level; its rising edge starts a recording
- track_select  input  1  0 = lower byte/RamLB, 1 = upper byte/RamUB; latched at start
- sample_valid  input  1  single-cycle strobe, sample_in valid
- sample_in  input  8  audio sample
- MemAdr  output  23  {2'b00, addr[20:0]}
- MemDB_out  output  16  write data to the bidirectional bus driver
- MemDB_oe  output  1  1 = drive MemDB_out onto MemDB
- RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB  output  1 each  active-low memory controls
- busy  output  1  recording in progress
- done  output  1  one-cycle pulse after the LAST_ADDR write completes
- overflow  output  1  sticky: a sample was dropped
- fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
Reset state (asynchronous, asserted while rst=1):
- All seven memory controls = 1; MemDB_oe=0; MemDB_out=0.
- addr=0, FIFO empty, busy=0, done=0, overflow=0.
- FSM in IDLE; track latch=0; record_en edge detector register=0.

Starting a recording:
- A rising edge of record_en (registered compare) while busy=0:
  - sets busy;
  - clears addr, overflow and FIFO;
  - latches track_select.

FIFO:
- Push on sample_valid when busy=1 and the FIFO is not full.
- sample_valid with the FIFO full: sample dropped, overflow set.
- sample_valid while busy=0: ignored, overflow unaffected.
- Push and pop in the same cycle are both performed; level is unchanged.

FSM (IDLE, SETUP, WRITE, RECOVER):
- IDLE
  - Controls all 1, MemDB_oe=0.
  - If busy and FIFO non-empty: pop the head into the data register and go to SETUP.
- SETUP (1 cycle)
  - RamCS=0, RamAdv=0, RamClk=0, MemOE=1, MemWR=1.
  - Selected lane strobe=0, other lane strobe=1; MemDB_oe=1.
  - Track 0: MemDB_out={8'h00,d}, RamLB=0, RamUB=1.
  - Track 1: MemDB_out={d,8'h00}, RamUB=0, RamLB=1.
- WRITE
  - Same as SETUP, but MemWR=0.
  - Lasts exactly WRITE_CYCLES cycles, counted by an internal counter cleared on SETUP entry.
- RECOVER (1 cycle)
  - MemWR=1; data and chip select still held.
  - On exit:
    - if addr==LAST_ADDR: addr returns to 0, busy clears, done pulses for 1 cycle, remaining FIFO contents are flushed;
    - otherwise addr increments.
  - Next state is IDLE.

Timing:
- One transaction occupies WRITE_CYCLES+2 cycles, then at least 1 IDLE cycle.
- Sustained throughput: 1 sample per WRITE_CYCLES+3 cycles.
- Latency: sample_valid sampled at edge N with the FSM idle and the FIFO empty gives SETUP at edge N+1 and MemWR low from edge N+2.
- MemAdr and MemDB_out are stable from SETUP through RECOVER. MemWR never falls in the same cycle that addr, data or the lane strobes change.

Edge cases:
- record_en falls mid-recording:
  - the in-flight write cycle completes through RECOVER;
  - the FIFO is then flushed, busy clears, no done pulse.
  - addr is ignored until the next start, which resets it.
- record_en rising edge while busy: ignored.
- rst mid-transaction: controls go inactive immediately and the bus is released.
- overflow stays set until the next recording start or reset.

Test Plan:
1. Reset, track_select=0, record_en 0→1, one sample 8'hA5:
   - SETUP then MemWR=0 for exactly 7 cycles;
   - MemAdr=0, MemDB_out=16'h00A5, RamLB=0, RamUB=1;
   - next sample is written at MemAdr=1.
2. track_select=1, sample 8'h3C:
   - MemDB_out=16'h3C00, RamUB=0, RamLB=1;
   - changing track_select mid-recording has no effect.
3. Burst of 6 consecutive sample_valid with FIFO_DEPTH=4 during a write:
   - 5 samples are written in order (the first is popped immediately);
   - overflow=1 and stays set; fifo_level peaks at 4.
4. LAST_ADDR=3, feed 5 samples at 1 per 20 cycles:
   - writes at addresses 0..3;
   - done pulses once after the address-3 RECOVER; busy=0;
   - 5th sample ignored, overflow=0.
5. Drop record_en during WRITE:
   - MemWR stays low for the full 7 cycles, then all controls go to 1 and busy=0;
   - FIFO empty; no done pulse.
6. Assert rst during WRITE:
   - in the same cycle, all controls = 1, MemDB_oe=0, MemAdr=0, fifo_level=0.

Source files
------------

// File: rtl/track_recorder_if.sv
// Asynchronous cellular RAM write bus driven by the track recorder.
// The master modport is the recorder side; the slave modport is the memory/pad side.
interface track_recorder_if;
    logic [22:0] MemAdr;
    logic [15:0] MemDB_out;
    logic        MemDB_oe;
    logic        RamAdv;
    logic        RamClk;
    logic        RamCS;
    logic        MemOE;
    logic        MemWR;
    logic        RamLB;
    logic        RamUB;

    modport master (
        output MemAdr, MemDB_out, MemDB_oe,
        output RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB
    );

    modport slave (
        input MemAdr, MemDB_out, MemDB_oe,
        input RamAdv, RamClk, RamCS, MemOE, MemWR, RamLB, RamUB
    );
endinterface

// File: rtl/track_recorder.sv
// Record path of the audio looper: buffers 8-bit samples and writes each one into
// a single byte lane of the 16-bit asynchronous RAM, one word address per sample.
module track_recorder #(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          WRITE_CYCLES = 7,
    parameter logic [20:0] LAST_ADDR    = 21'h1FFFFF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        record_en,
    input  logic                        track_select,
    input  logic                        sample_valid,
    input  logic [7:0]                  sample_in,
    track_recorder_if.master            mem,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(WRITE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WRITE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, RECOVER} state_t;
    state_t state, state_next;

    logic             rec_en_q;
    logic             track_q;
    logic [20:0]      addr;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] wr_cnt;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             full, empty, start, push, pop, stop, last_write;
    logic             cs_n, wr_n, lb_n, ub_n, db_oe;

    assign full       = (level == LVL_W'(FIFO_DEPTH));
    assign empty      = (level == '0);
    assign start      = record_en && !rec_en_q && !busy;
    assign push       = busy && sample_valid && !full;
    assign last_write = (state == RECOVER) && (addr == LAST_ADDR);

    // A recording ends either after the final address or when record_en is gone;
    // a write already in flight always runs through RECOVER first.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        stop       = 1'b0;
        case (state)
            IDLE: begin
                if (busy && !record_en) begin
                    stop = 1'b1;
                end else if (busy && !empty) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = WRITE;
            WRITE: begin
                if (wr_cnt == CNT_LAST) state_next = RECOVER;
            end
            RECOVER: begin
                state_next = IDLE;
                if (last_write || !record_en) stop = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rec_en_q <= 1'b0;
            track_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            addr     <= '0;
            data_q   <= '0;
            wr_cnt   <= '0;
        end else begin
            state    <= state_next;
            rec_en_q <= record_en;
            done     <= last_write;
            if (start) begin
                busy     <= 1'b1;
                track_q  <= track_select;
                overflow <= 1'b0;
            end else begin
                if (stop) busy <= 1'b0;
                if (busy && sample_valid && full) overflow <= 1'b1;
            end
            if (start) begin
                addr <= '0;
            end else if (state == RECOVER) begin
                addr <= last_write ? '0 : addr + 21'd1;
            end
            if (pop) data_q <= fifo_mem[rd_ptr];
            if (pop) begin
                wr_cnt <= '0;
            end else if (state == WRITE) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (start || stop) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Strobes are registered from the next state so they switch glitch-free and
    // MemWR only moves one cycle after address, data and lane strobes settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_n  <= 1'b1;
            wr_n  <= 1'b1;
            lb_n  <= 1'b1;
            ub_n  <= 1'b1;
            db_oe <= 1'b0;
        end else begin
            cs_n  <= (state_next == IDLE);
            wr_n  <= (state_next != WRITE);
            lb_n  <= (state_next == IDLE) || track_q;
            ub_n  <= (state_next == IDLE) || !track_q;
            db_oe <= (state_next != IDLE);
        end
    end

    assign mem.MemAdr    = {2'b00, addr};
    assign mem.MemDB_out = track_q ? {data_q, 8'h00} : {8'h00, data_q};
    assign mem.MemDB_oe  = db_oe;
    assign mem.RamAdv    = cs_n;
    assign mem.RamClk    = cs_n;
    assign mem.RamCS     = cs_n;
    assign mem.MemOE     = 1'b1;
    assign mem.MemWR     = wr_n;
    assign mem.RamLB     = lb_n;
    assign mem.RamUB     = ub_n;
    assign fifo_level    = level;
endmodule
